fetcher: RTL and testbench
==========================

// Module: fetcher
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the decoder.
//  On each start pulse it reads one 32-bit instruction word at the given pc over a
//  single-beat read bus (address channel + data channel, valid/ready).
//  It then presents {pc_out, instr_raw} to the decoder with a completed flag.
//  A misaligned pc is reported as a fault without issuing any bus access.
// PARAMETERS
//  NOP_INSTR    32'h0000_0013  value driven on instr_raw after reset and on fault (addi x0,x0,0)
//  ALIGN_CHECK  1              1: pc[1:0]!=0 raises fault, no bus access; 0: address issued as-is
// PORTS
//  clk          in   1   clock, rising edge
//  rstn         in   1   asynchronous active-low reset
//  enabled      in   1   start pulse; sampled only in IDLE or DONE
//  completed    out  1   fetch result valid; = done_flag & !enabled
//  pc           in   32  address to fetch, sampled with enabled
//  pc_out       out  32  pc of the held instruction
//  instr_raw    out  32  fetched instruction word (NOP_INSTR on fault)
//  fault        out  1   misaligned-fetch indication for the held result
//  mem_araddr   out  32  read address
//  mem_arvalid  out  1   read address valid
//  mem_arready  in   1   read address accepted
//  mem_rdata    in   32  read data
//  mem_rvalid   in   1   read data valid
//  mem_rready   out  1   fetcher ready to accept read data
// BEHAVIOUR
//  Reset (rstn low, async):
//   - state=IDLE, done_flag=0, completed=0, fault=0.
//   - pc_out=0, instr_raw=NOP_INSTR, mem_araddr=0, mem_arvalid=0, mem_rready=0.
//   - An in-flight bus transaction is abandoned; a late rvalid after reset is ignored (rready=0).
//  FSM states: IDLE, ADDR, DATA, DONE; all outputs are registered.
//  IDLE/DONE with enabled=1 at the edge:
//   - pc_out<=pc; done_flag<=0.
//   - If ALIGN_CHECK and pc[1:0]!=0: fault<=1, instr_raw<=NOP_INSTR, done_flag<=1,
//     state<=DONE; no bus access.
//   - Otherwise: fault<=0, mem_araddr<=pc, mem_arvalid<=1, state<=ADDR.
//  ADDR: hold mem_arvalid and mem_araddr stable until mem_arready=1.
//   - On the handshake edge: arvalid<=0, rready<=1, state<=DATA.
//  DATA: hold mem_rready=1 until mem_rvalid=1.
//   - On that edge: instr_raw<=mem_rdata, rready<=0, done_flag<=1, state<=DONE.
//   - mem_rvalid seen outside DATA is ignored.
//  DONE: instr_raw, pc_out and fault are held until the next accepted enabled.
//   - completed stays high for as long as enabled is low.
//  enabled asserted in ADDR/DATA is ignored; the fetch completes with the original pc.
//  completed drops combinationally in any cycle where enabled=1.
//  Latency, zero-wait bus:
//   - enabled@c0 -> arvalid@c1; arready@c1 -> rready@c2; rvalid@c2 -> completed@c3.
//   - Each wait cycle on arready or rvalid adds one cycle.
//  Fault path: enabled@c0 -> completed@c1.
//  No counters wrap; pc is passed through unmodified (no increment in this block).
// TESTING
//  1. Zero-wait fetch: pc=0x100, memory[0x100]=0x00A00093, arready/rvalid immediate
//     -> completed@c3, instr_raw=0x00A00093, pc_out=0x100, fault=0.
//  2. Backpressure: arready delayed 3 cycles, rvalid delayed 2 cycles
//     -> araddr/arvalid stable throughout, completed 5 cycles later than case 1.
//  3. Misaligned: pc=0x102 -> no arvalid ever, completed@c1, fault=1,
//     instr_raw=0x00000013, pc_out=0x102.
//  4. Spurious start: enabled pulsed again in ADDR with pc=0x200
//     -> ignored, result is for 0x100.
//  5. Back-to-back: enabled held in DONE with pc=0x104
//     -> completed low while enabled=1, new fetch starts, old outputs held until replaced.
//  6. Reset mid-DATA: rstn low while rready=1 -> rready/arvalid=0 immediately,
//     instr_raw=NOP_INSTR, completed=0; rvalid after release is ignored.

Source files
------------

// File: rtl/fetcher.sv
// Instruction fetch stage: reads one 32-bit word at pc per start pulse and presents {pc_out, instr_raw}.
// Latency: enabled@c0 -> completed@c3 on a zero-wait bus (+1 per arready/rvalid wait); misaligned pc -> completed@c1.
// Backpressure: arvalid/araddr held until arready; rready held until rvalid; enabled ignored while a fetch is in flight.
module fetcher #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    output logic        completed,
    input  logic [31:0] pc,
    output logic [31:0] pc_out,
    output logic [31:0] instr_raw,
    output logic        fault,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        done_flag_q, done_flag_d;
    logic [31:0] pc_out_d;
    logic [31:0] instr_raw_d;
    logic        fault_d;
    logic [31:0] mem_araddr_d;
    logic        mem_arvalid_d;
    logic        mem_rready_d;
    logic        misaligned;

    assign misaligned = ALIGN_CHECK && (pc[1:0] != 2'b00);

    // A pending result is withdrawn in the very cycle a new start is requested.
    assign completed = done_flag_q & ~enabled;

    always_comb begin
        state_d       = state_q;
        done_flag_d   = done_flag_q;
        pc_out_d      = pc_out;
        instr_raw_d   = instr_raw;
        fault_d       = fault;
        mem_araddr_d  = mem_araddr;
        mem_arvalid_d = mem_arvalid;
        mem_rready_d  = mem_rready;

        case (state_q)
            IDLE, DONE: begin
                if (enabled) begin
                    pc_out_d    = pc;
                    done_flag_d = 1'b0;
                    if (misaligned) begin
                        fault_d     = 1'b1;
                        instr_raw_d = NOP_INSTR;
                        done_flag_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        fault_d       = 1'b0;
                        mem_araddr_d  = pc;
                        mem_arvalid_d = 1'b1;
                        state_d       = ADDR;
                    end
                end
            end
            ADDR: begin
                if (mem_arready) begin
                    mem_arvalid_d = 1'b0;
                    mem_rready_d  = 1'b1;
                    state_d       = DATA;
                end
            end
            DATA: begin
                if (mem_rvalid) begin
                    instr_raw_d  = mem_rdata;
                    mem_rready_d = 1'b0;
                    done_flag_d  = 1'b1;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            done_flag_q <= 1'b0;
            pc_out      <= 32'h0;
            instr_raw   <= NOP_INSTR;
            fault       <= 1'b0;
            mem_araddr  <= 32'h0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_flag_q <= done_flag_d;
            pc_out      <= pc_out_d;
            instr_raw   <= instr_raw_d;
            fault       <= fault_d;
            mem_araddr  <= mem_araddr_d;
            mem_arvalid <= mem_arvalid_d;
            mem_rready  <= mem_rready_d;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a cycle-by-cycle vector table plus a hand-written reset-in-DATA sequence.
module tb_fetcher;

    logic        clk;
    logic        rstn;
    logic        enabled;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] pc_out;
    logic [31:0] instr_raw;
    logic        fault;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rready;

    int checks = 0;
    int errors = 0;

    fetcher dut (
        .clk         (clk),
        .rstn        (rstn),
        .enabled     (enabled),
        .completed   (completed),
        .pc          (pc),
        .pc_out      (pc_out),
        .instr_raw   (instr_raw),
        .fault       (fault),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        ar;
        logic        rv;
        logic [31:0] rd;
        logic        e_cmp;
        logic        e_arv;
        logic        e_rr;
        logic        e_flt;
        logic [31:0] e_pco;
        logic [31:0] e_ins;
        logic [31:0] e_ara;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [31:0] pcv, input logic ar,
                                input logic rv, input logic [31:0] rd, input logic e_cmp,
                                input logic e_arv, input logic e_rr, input logic e_flt,
                                input logic [31:0] e_pco, input logic [31:0] e_ins,
                                input logic [31:0] e_ara);
        vec_t v;
        v.en = en; v.pc = pcv; v.ar = ar; v.rv = rv; v.rd = rd;
        v.e_cmp = e_cmp; v.e_arv = e_arv; v.e_rr = e_rr; v.e_flt = e_flt;
        v.e_pco = e_pco; v.e_ins = e_ins; v.e_ara = e_ara;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h00A0_0093;  // memory[0x100]
    localparam logic [31:0] I1  = 32'h0010_0113;  // memory[0x104]

    initial begin
        rstn = 1'b0; enabled = 1'b0; pc = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        //          en  pc          ar rv rd             cmp arv rr flt pc_out      instr  araddr
        // zero-wait fetch of 0x100, then a stray rvalid while DONE
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,   NOP, 32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         0, 1, 0, 0, 32'h100, NOP, 32'h100));
        vecs.push_back(mk(0, 32'h0,   0, 1, I0,            0, 0, 1, 0, 32'h100, NOP, 32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 0, 32'h100, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 32'hDEADBEEF,  1, 0, 0, 0, 32'h100, I0,  32'h0));
        // backpressure: arready 3 waits, rvalid 2 waits; stray rvalid in ADDR
        vecs.push_back(mk(1, 32'h104, 0, 0, 32'h0,         0, 0, 0, 0, 32'h100, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 32'hBAD0BAD0,  0, 1, 0, 0, 32'h104, I0,  32'h104));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         0, 1, 0, 0, 32'h104, I0,  32'h104));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         0, 1, 0, 0, 32'h104, I0,  32'h104));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         0, 1, 0, 0, 32'h104, I0,  32'h104));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         0, 0, 1, 0, 32'h104, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         0, 0, 1, 0, 32'h104, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 1, I1,            0, 0, 1, 0, 32'h104, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 0, 32'h104, I1,  32'h0));
        // misaligned pc: no bus access, fault result one cycle later
        vecs.push_back(mk(1, 32'h102, 0, 0, 32'h0,         0, 0, 0, 0, 32'h104, I1,  32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 1, 32'h102, NOP, 32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 1, 32'h102, NOP, 32'h0));
        // spurious start with pc=0x200 while in ADDR is ignored
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,         0, 0, 0, 1, 32'h102, NOP, 32'h0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,         0, 1, 0, 0, 32'h100, NOP, 32'h100));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         0, 1, 0, 0, 32'h100, NOP, 32'h100));
        vecs.push_back(mk(0, 32'h0,   0, 1, I0,            0, 0, 1, 0, 32'h100, NOP, 32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 0, 32'h100, I0,  32'h0));
        // back-to-back: enabled held across DONE->ADDR, old instr held until replaced
        vecs.push_back(mk(1, 32'h104, 0, 0, 32'h0,         0, 0, 0, 0, 32'h100, I0,  32'h0));
        vecs.push_back(mk(1, 32'h104, 1, 0, 32'h0,         0, 1, 0, 0, 32'h104, I0,  32'h104));
        vecs.push_back(mk(0, 32'h0,   0, 1, I1,            0, 0, 1, 0, 32'h104, I0,  32'h0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 0, 32'h104, I1,  32'h0));

        #12;
        chk("rst_completed", {31'b0, completed},   32'h0);
        chk("rst_arvalid",   {31'b0, mem_arvalid}, 32'h0);
        chk("rst_rready",    {31'b0, mem_rready},  32'h0);
        chk("rst_fault",     {31'b0, fault},       32'h0);
        chk("rst_pc_out",    pc_out,               32'h0);
        chk("rst_instr",     instr_raw,            NOP);
        chk("rst_araddr",    mem_araddr,           32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            enabled = vecs[i].en; pc = vecs[i].pc;
            mem_arready = vecs[i].ar; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
            #2;
            chk($sformatf("v%0d_completed", i), {31'b0, completed},   {31'b0, vecs[i].e_cmp});
            chk($sformatf("v%0d_arvalid", i),   {31'b0, mem_arvalid}, {31'b0, vecs[i].e_arv});
            chk($sformatf("v%0d_rready", i),    {31'b0, mem_rready},  {31'b0, vecs[i].e_rr});
            chk($sformatf("v%0d_fault", i),     {31'b0, fault},       {31'b0, vecs[i].e_flt});
            chk($sformatf("v%0d_pc_out", i),    pc_out,               vecs[i].e_pco);
            chk($sformatf("v%0d_instr", i),     instr_raw,            vecs[i].e_ins);
            if (vecs[i].e_arv)
                chk($sformatf("v%0d_araddr", i), mem_araddr, vecs[i].e_ara);
            @(posedge clk);
            #1;
        end

        // reset asserted while the fetcher waits in DATA
        enabled = 1'b1; pc = 32'h300; mem_arready = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        enabled = 1'b0; mem_arready = 1'b1;
        @(posedge clk); #1;
        mem_arready = 1'b0;
        chk("rstdata_rready_before", {31'b0, mem_rready}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rstdata_rready",    {31'b0, mem_rready},  32'h0);
        chk("rstdata_arvalid",   {31'b0, mem_arvalid}, 32'h0);
        chk("rstdata_completed", {31'b0, completed},   32'h0);
        chk("rstdata_instr",     instr_raw,            NOP);
        chk("rstdata_pc_out",    pc_out,               32'h0);
        @(negedge clk);
        rstn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("late_rvalid%0d_completed", k), {31'b0, completed},  32'h0);
            chk($sformatf("late_rvalid%0d_rready", k),    {31'b0, mem_rready}, 32'h0);
            chk($sformatf("late_rvalid%0d_instr", k),     instr_raw,           NOP);
        end
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
